// File: rtl/store_pkg.sv
// Shared encodings and helpers for the sub-word store read-modify-write sequencer.
package store_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    // Natural alignment: the low address bits below the access size must be zero.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return off[1:0] != 2'b00;
            SZ_D:    return off != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lane_merge.sv
// Inserts a right-aligned byte/half/word/dword into an existing memory word at a byte lane.
module lane_merge #(
    parameter int DATA_W = 32,
    localparam int LANES = DATA_W / 8,
    localparam int OFF_W = $clog2(LANES)
) (
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_size,
    input  logic [OFF_W-1:0]  i_off,
    output logic [DATA_W-1:0] o_merged
);

    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_merged;

    // Lanes inside [off, off + 2^size) take the shifted store data, the rest keep the old word.
    always_comb begin
        w_shifted = i_data << {i_off, 3'b000};
        w_merged  = i_old;
        for (int l = 0; l < LANES; l++) begin
            if (l >= int'(i_off) && l < int'(i_off) + (1 << i_size)) begin
                w_merged[8*l +: 8] = w_shifted[8*l +: 8];
            end
        end
    end

    assign o_merged = w_merged;

endmodule

// File: rtl/store_merge_rmw.sv
// Store sequencer: full-width stores write through, sub-word stores read, merge and write back.
module store_merge_rmw
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    localparam int LANES = DATA_W / 8,
    localparam int OFF_W = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam logic [1:0] FULL_SZ = (DATA_W == 64) ? SZ_D : SZ_W;

    state_t            r_state;
    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done;
    logic              r_err;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [2:0]        w_off3;
    logic              w_reject;
    logic [ADDR_W-1:0] w_word_addr;
    logic [DATA_W-1:0] w_merged;

    assign w_off3      = 3'(req_addr[OFF_W-1:0]);
    assign w_reject    = ((req_size == SZ_D) && (DATA_W == 32)) || is_misaligned(req_size, w_off3);
    assign w_word_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    lane_merge #(.DATA_W(DATA_W)) u_merge (
        .i_old    (mem_rdata),
        .i_data   (r_wdata),
        .i_size   (r_size),
        .i_off    (r_off),
        .o_merged (w_merged)
    );

    // Memory command fields only change on state transitions, so they hold under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_off       <= '0;
            r_size      <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_off      <= req_addr[OFF_W-1:0];
                            r_size     <= req_size;
                            r_wdata    <= req_wdata;
                            r_mem_addr <= w_word_addr;
                            r_mem_req  <= 1'b1;
                            if (req_size == FULL_SZ) begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= req_wdata;
                                r_state     <= WR_REQ;
                            end else begin
                                r_mem_we <= 1'b0;
                                r_state  <= RD_REQ;
                            end
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        r_mem_wdata <= w_merged;
                        r_mem_we    <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
